priority_request_arbiter: RTL

Upstream stage of the traffic-light top. Conditions the two raw lane-presence sensors (east, west) and arbitrates them into the 2-bit `priority` code the top-level FSM consumes. Also accepts a serve acknowledge from the controller. Each sensor is debounced, its request is latched, and grants alternate round-robin when both lanes are waiting.

---
 rtl/priority_request_arbiter_pkg.sv | 31 +++
 rtl/sensor_debounce.sv | 50 +++++
 rtl/priority_request_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/priority_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : priority_request_arbiter_pkg
// Brief   : Shared priority codes and arbiter state encodings for the
//           lane-request arbiter and the traffic-light controller.
// Rev     : 1.0  initial release
// ============================================================================
package priority_request_arbiter_pkg;

    localparam logic [1:0] PRIO_NONE = 2'b00;
    localparam logic [1:0] PRIO_EAST = 2'b01;
    localparam logic [1:0] PRIO_WEST = 2'b10;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE    = 2'd0;
    localparam arb_state_t ARB_GRANT_E = 2'd1;
    localparam arb_state_t ARB_GRANT_W = 2'd2;

    function automatic logic [1:0] prio_of_state(input arb_state_t s);
        logic [1:0] p;
        case (s)
            ARB_GRANT_E: p = PRIO_EAST;
            ARB_GRANT_W: p = PRIO_WEST;
            default:     p = PRIO_NONE;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module  : sensor_debounce
// Brief   : 2-flop synchronizer plus stability counter; pulses o_rise in the
//           cycle the debounced level is about to go high.
// Rev     : 1.0  initial release
// ============================================================================
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_expire;

    assign w_differ = r_sync[1] ^ r_level;
    assign w_expire = w_differ && (r_cnt == c_DEB_LAST);
    // Rise is combinational so the request latch sets on the same edge the level flips.
    assign o_rise   = w_expire & r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_expire) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/priority_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : priority_request_arbiter
// Brief   : Debounces east/west presence sensors, latches requests and grants
//           them round-robin as a registered 2-bit priority code.
//           Optional grant hold timeout: define PRIO_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module priority_request_arbiter
    import priority_request_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_MAX        = 60,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sensor_east,
    input  logic       i_sensor_west,
    input  logic       i_serve_ack,
    output logic [1:0] o_priority,
    output logic [1:0] o_pending
`ifdef PRIO_TIMEOUT_EN
    ,
    output logic       o_grant_timeout
`endif
);

    if ((2 ** CNT_W) <= DEBOUNCE_CYCLES || (2 ** CNT_W) <= HOLD_MAX) begin : g_cnt_w_check
        $error("CNT_W too narrow for DEBOUNCE_CYCLES/HOLD_MAX");
    end

    logic       w_rise_e;
    logic       w_rise_w;
    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [1:0] r_priority;
    logic [1:0] w_prio_nxt;
    logic [1:0] r_pending;
    logic       r_last_west;
    logic       w_leave;
    logic       w_clr_e;
    logic       w_clr_w;
    logic       w_hold_exp;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_east (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (i_sensor_east),
        .o_rise (w_rise_e)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_west (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (i_sensor_west),
        .o_rise (w_rise_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_priority <= PRIO_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_priority <= w_prio_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (r_pending == 2'b11) begin
                    w_state_nxt = r_last_west ? ARB_GRANT_E : ARB_GRANT_W;
                end else if (r_pending[0]) begin
                    w_state_nxt = ARB_GRANT_E;
                end else if (r_pending[1]) begin
                    w_state_nxt = ARB_GRANT_W;
                end
            end
            ARB_GRANT_E, ARB_GRANT_W: begin
                if (i_serve_ack || w_hold_exp) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_prio_nxt = prio_of_state(w_state_nxt);
        w_leave    = (r_state != ARB_IDLE) && (w_state_nxt == ARB_IDLE);
        w_clr_e    = w_leave && (r_state == ARB_GRANT_E);
        w_clr_w    = w_leave && (r_state == ARB_GRANT_W);
    end

    // A new rise in the same cycle as the clear wins, so the request is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= 2'b00;
            r_last_west <= 1'b1;
        end else begin
            r_pending[0] <= (r_pending[0] & ~w_clr_e) | w_rise_e;
            r_pending[1] <= (r_pending[1] & ~w_clr_w) | w_rise_w;
            if (w_clr_e) begin
                r_last_west <= 1'b0;
            end else if (w_clr_w) begin
                r_last_west <= 1'b1;
            end
        end
    end

`ifdef PRIO_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] r_hold;
    logic             r_grant_timeout;
    logic             w_timeout;

    assign w_hold_exp = (r_state != ARB_IDLE) && (r_hold == c_HOLD_LAST);
    assign w_timeout  = w_hold_exp & ~i_serve_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold          <= '0;
            r_grant_timeout <= 1'b0;
        end else begin
            r_hold          <= (r_state == ARB_IDLE || w_state_nxt == ARB_IDLE) ? '0 : r_hold + 1'b1;
            r_grant_timeout <= w_timeout;
        end
    end

    assign o_grant_timeout = r_grant_timeout;
`else
    assign w_hold_exp = 1'b0;
`endif

    assign o_priority = r_priority;
    assign o_pending  = r_pending;

endmodule
`default_nettype wire
